ysyx_23060208_dsram_slave: RTL and testbench



---
 rtl/ysyx_23060208_dsram_slave_if.sv | 64 ++++++
 rtl/ysyx_23060208_dsram_slave.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_23060208_dsram_slave.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060208_dsram_slave_if.sv
// +-----------------------------------------------------------------------------+
// | ysyx_23060208_dsram_slave_if: AXI4 AW/W/B/AR/R bundle for the data SRAM.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface ysyx_23060208_dsram_slave_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060208_dsram_slave.sv
// +-----------------------------------------------------------------------------+
// | ysyx_23060208_dsram_slave: single-beat AXI4 data SRAM with fixed latency.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module ysyx_23060208_dsram_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          LAT_W     = 2,
  parameter int          LAT_R     = 2
) (
  input  wire logic                    clock,
  input  wire logic                    reset,
  ysyx_23060208_dsram_slave_if.slave   bus
);
  localparam int          c_idx_w = $clog2(MEM_WORDS);
  localparam logic [31:0] c_span  = 32'(MEM_WORDS * 8);
  localparam logic [7:0]  c_lat_w = 8'(LAT_W);
  localparam logic [7:0]  c_lat_r = 8'(LAT_R);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  logic [63:0] r_mem [MEM_WORDS];

  w_state_t    r_wstate;
  logic        r_awready, r_wready, r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_bid;
  logic [31:0] r_awaddr;
  logic [7:0]  r_awlen;
  logic [2:0]  r_awsize;
  logic [7:0]  r_wcnt;

  r_state_t    r_rstate;
  logic        r_arready, r_rvalid, r_rlast;
  logic [1:0]  r_rresp;
  logic [3:0]  r_rid;
  logic [63:0] r_rdata;
  logic [7:0]  r_rcnt;

  logic [31:0]        w_w_off, w_r_off;
  logic [c_idx_w-1:0] w_w_idx, w_r_idx;
  logic [1:0]         w_wresp, w_rresp;
  logic               w_commit;
  logic               w_unused;

  // The wrapped offset of an address below the base is always >= span,
  // so a single compare covers both ends of the window.
  assign w_w_off = r_awaddr - ADDR_BASE;
  assign w_r_off = bus.araddr - ADDR_BASE;
  assign w_w_idx = w_w_off[c_idx_w+2:3];
  assign w_r_idx = w_r_off[c_idx_w+2:3];

  assign w_wresp = (w_w_off >= c_span) ? 2'b11 :
                   ((r_awlen != 8'd0) || (r_awsize > 3'd3) || !bus.wlast) ? 2'b10 : 2'b00;
  assign w_rresp = (w_r_off >= c_span) ? 2'b11 :
                   ((bus.arlen != 8'd0) || (bus.arsize > 3'd3)) ? 2'b10 : 2'b00;

  assign w_commit = (r_wstate == W_DATA) && bus.wvalid && (w_wresp == 2'b00);
  assign w_unused = &{1'b0, bus.awburst, bus.arburst, w_w_off, w_r_off};

  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.wstrb[i]) r_mem[w_w_idx][i*8 +: 8] <= bus.wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_bid     <= 4'd0;
      r_awaddr  <= 32'd0;
      r_awlen   <= 8'd0;
      r_awsize  <= 3'd0;
      r_wcnt    <= 8'd0;
    end else begin
      case (r_wstate)
        W_IDLE: if (bus.awvalid) begin
          r_awaddr  <= bus.awaddr;
          r_awlen   <= bus.awlen;
          r_awsize  <= bus.awsize;
          r_bid     <= bus.awid;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (bus.wvalid) begin
          r_wready <= 1'b0;
          r_bresp  <= w_wresp;
          if (c_lat_w == 8'd0) begin
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt   <= c_lat_w;
            r_wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          r_wcnt <= r_wcnt - 8'd1;
          if (r_wcnt == 8'd1) begin
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (bus.bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read data is captured at the AR edge, so a write committing on that edge stays invisible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rid     <= 4'd0;
      r_rdata   <= 64'd0;
      r_rcnt    <= 8'd0;
    end else begin
      case (r_rstate)
        R_IDLE: if (bus.arvalid) begin
          r_arready <= 1'b0;
          r_rid     <= bus.arid;
          r_rresp   <= w_rresp;
          r_rdata   <= (w_rresp == 2'b00) ? r_mem[w_r_idx] : 64'd0;
          if (c_lat_r == 8'd0) begin
            r_rvalid <= 1'b1;
            r_rlast  <= 1'b1;
            r_rstate <= R_RESP;
          end else begin
            r_rcnt   <= c_lat_r;
            r_rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          r_rcnt <= r_rcnt - 8'd1;
          if (r_rcnt == 8'd1) begin
            r_rvalid <= 1'b1;
            r_rlast  <= 1'b1;
            r_rstate <= R_RESP;
          end
        end
        R_RESP: if (bus.rready) begin
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
          r_arready <= 1'b1;
          r_rstate  <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bresp   = r_bresp;
  assign bus.bid     = r_bid;
  assign bus.arready = r_arready;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign bus.rlast   = r_rlast;
  assign bus.rid     = r_rid;
endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060208_dsram_slave.sv
// +-----------------------------------------------------------------------------+
// | tb_ysyx_23060208_dsram_slave: scoreboard bench with a word-array model.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ysyx_23060208_dsram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 1024;
  localparam int          LATW  = 2;
  localparam int          LATR  = 2;
  localparam int          TMO   = 400;

  logic clock = 1'b0;
  logic reset = 1'b0;
  ysyx_23060208_dsram_slave_if bus();

  ysyx_23060208_dsram_slave #(
    .ADDR_BASE(BASE), .MEM_WORDS(WORDS), .LAT_W(LATW), .LAT_R(LATR)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [63:0] data;
    longint      t;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  longint      cyc      = 0;
  exp_t        bq[$];
  exp_t        rq[$];
  logic [63:0] mdl [int];
  int          bp    = 0;
  logic        rhold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=no_event required=event_within_%0d_cycles", name, TMO);
  endtask

  // Reference rules: window check, then burst/size/last legality.
  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [7:0] len,
                                          input logic [2:0] sz, input logic last);
    longint la = longint'({32'h0, a});
    longint lo = longint'({32'h0, BASE});
    if (la < lo || la >= lo + longint'(WORDS) * 8) return 2'b11;
    if (len != 8'd0 || sz > 3'd3 || !last) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 8);
  endfunction

  function automatic logic [31:0] set_addr(input int k);
    int idx = (k < 8) ? k : WORDS - 16 + k;
    return 32'(longint'({32'h0, BASE}) + longint'(idx) * 8);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int k = int'($urandom_range(18));
    if (k < 16) return set_addr(k) + 32'($urandom_range(7));
    if (k == 16) return BASE - 32'd1 - 32'($urandom_range(7));
    if (k == 17) return 32'(longint'({32'h0, BASE}) + longint'(WORDS) * 8) + 32'($urandom_range(7));
    return 32'h0000_1000;
  endfunction

  function automatic logic ready_of(input int ch);
    case (ch)
      0:       return bus.awready;
      1:       return bus.wready;
      default: return bus.arready;
    endcase
  endfunction

  task automatic wait_hs(input int ch, input string name);
    int n = 0;
    @(negedge clock);
    while (!ready_of(ch)) begin
      if (n >= TMO) begin
        timeout(name);
        break;
      end
      n++;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic aw_go(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz);
    bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awsize = sz;
    bus.awburst = 2'($urandom_range(3));
    bus.awvalid = 1'b1;
    wait_hs(0, "aw");
    bus.awvalid = 1'b0;
  endtask

  task automatic w_go(input logic [63:0] d, input logic [7:0] s, input logic last);
    bus.wdata = d; bus.wstrb = s; bus.wlast = last;
    bus.wvalid = 1'b1;
    wait_hs(1, "w");
    bus.wvalid = 1'b0;
  endtask

  task automatic ar_go(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz);
    bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arsize = sz;
    bus.arburst = 2'($urandom_range(3));
    bus.arvalid = 1'b1;
    wait_hs(2, "ar");
    bus.arvalid = 1'b0;
  endtask

  // Sometimes present W before AW: the slave must not take it early.
  task automatic wr(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz,
                    input logic [63:0] d, input logic [7:0] s, input logic last);
    if ($urandom_range(3) == 0) begin
      bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
    end
    aw_go(a, id, len, sz);
    w_go(d, s, last);
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < TMO) begin
      @(negedge clock);
      n++;
    end
    if (n >= TMO) timeout("drain");
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock); #2; reset = 1'b0;
    repeat (2) @(negedge clock);
    #2; reset = 1'b1;
    @(posedge clock); #1;
  endtask

  initial forever @(posedge clock) cyc++;

  initial begin
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus.bready = (int'($urandom_range(99)) >= bp);
      bus.rready = !rhold && (int'($urandom_range(99)) >= bp);
    end
  end

  // Observer: turns bus handshakes into expectations; reads see the array before same-edge writes.
  initial begin
    logic [31:0] pa;
    logic [7:0]  pl;
    logic [2:0]  ps;
    logic [3:0]  pid;
    logic [63:0] w;
    exp_t        e;
    pa = '0; pl = '0; ps = '0; pid = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bq.delete();
        rq.delete();
      end else begin
        if (bus.arvalid && bus.arready) begin
          e.id   = bus.arid;
          e.resp = exp_resp(bus.araddr, bus.arlen, bus.arsize, 1'b1);
          e.data = (e.resp == 2'b00) ? mdl[widx(bus.araddr)] : 64'd0;
          e.t    = cyc + 1;
          rq.push_back(e);
        end
        if (bus.awvalid && bus.awready) begin
          pa = bus.awaddr; pl = bus.awlen; ps = bus.awsize; pid = bus.awid;
        end
        if (bus.wvalid && bus.wready) begin
          e.id   = pid;
          e.resp = exp_resp(pa, pl, ps, bus.wlast);
          e.data = 64'd0;
          e.t    = cyc + 1;
          if (e.resp == 2'b00) begin
            w = mdl[widx(pa)];
            for (int i = 0; i < 8; i++) if (bus.wstrb[i]) w[i*8 +: 8] = bus.wdata[i*8 +: 8];
            mdl[widx(pa)] = w;
          end
          bq.push_back(e);
        end
      end
    end
  end

  // Monitor: pops and compares whenever the slave presents a response.
  initial begin
    logic        b_seen, r_seen, b_prev, r_prev;
    logic [5:0]  b_hold;
    logic [70:0] r_hold;
    exp_t        e;
    b_seen = 1'b0; r_seen = 1'b0; b_prev = 1'b0; r_prev = 1'b0;
    b_hold = '0; r_hold = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("rst_awready", 64'(bus.awready), 64'd1);
        check("rst_arready", 64'(bus.arready), 64'd1);
        check("rst_outs", 64'({bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.bresp, bus.rresp, bus.bid, bus.rid}), 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        b_seen = 1'b0; r_seen = 1'b0; b_prev = 1'b0; r_prev = 1'b0;
      end else begin
        if (b_prev) check("awready_after_b", 64'(bus.awready), 64'd1);
        if (r_prev) check("arready_after_r", 64'(bus.arready), 64'd1);
        b_prev = bus.bvalid && bus.bready;
        r_prev = bus.rvalid && bus.rready;
        if (bus.bvalid) begin
          check("awready_busy", 64'(bus.awready), 64'd0);
          check("b_expected", 64'(bq.size()), 64'd1);
          if (bq.size() != 0) begin
            e = bq[0];
            if (!b_seen) begin
              check("b_latency", 64'(cyc - e.t), 64'(LATW));
              b_seen = 1'b1;
              b_hold = {bus.bid, bus.bresp};
            end else begin
              check("b_stable", 64'({bus.bid, bus.bresp}), 64'(b_hold));
            end
            check("bid", 64'(bus.bid), 64'(e.id));
            check("bresp", 64'(bus.bresp), 64'(e.resp));
            if (bus.bready) begin
              void'(bq.pop_front());
              b_seen = 1'b0;
            end
          end
        end
        if (bus.rvalid) begin
          check("arready_busy", 64'(bus.arready), 64'd0);
          check("r_expected", 64'(rq.size()), 64'd1);
          if (rq.size() != 0) begin
            e = rq[0];
            if (!r_seen) begin
              check("r_latency", 64'(cyc - e.t), 64'(LATR));
              r_seen = 1'b1;
              r_hold = {bus.rid, bus.rresp, bus.rlast, bus.rdata};
            end else begin
              check("r_stable_hi", 64'(r_hold[70:64]), 64'({bus.rid, bus.rresp, bus.rlast}));
              check("r_stable_data", bus.rdata, r_hold[63:0]);
            end
            check("rid", 64'(bus.rid), 64'(e.id));
            check("rresp", 64'(bus.rresp), 64'(e.resp));
            check("rlast", 64'(bus.rlast), 64'd1);
            check("rdata", bus.rdata, e.data);
            if (bus.rready) begin
              void'(rq.pop_front());
              r_seen = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    repeat (3) @(posedge clock);
    @(negedge clock); #2; reset = 1'b1;
    @(posedge clock); #1;

    // Known-value sequence at 0x8000_0010.
    wr(32'h8000_0010, 4'd3, 8'd0, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    ar_go(32'h8000_0010, 4'd5, 8'd0, 3'd3);
    wr(32'h8000_0010, 4'd6, 8'd0, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b1);
    ar_go(32'h8000_0014, 4'd7, 8'd0, 3'd3);
    ar_go(32'h0000_1000, 4'd8, 8'd0, 3'd3);
    wr(32'h8000_0010, 4'd9, 8'd1, 3'd3, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
    ar_go(32'h8000_0010, 4'd10, 8'd0, 3'd3);
    drain();

    for (int k = 0; k < 16; k++)
      wr(set_addr(k), 4'(k), 8'd0, 3'd3, {$urandom, $urandom}, 8'hFF, 1'b1);
    drain();

    // Read held off for more than ten cycles.
    rhold = 1'b1;
    ar_go(set_addr(15), 4'd11, 8'd0, 3'd3);
    repeat (14) @(posedge clock);
    #1; rhold = 1'b0;
    drain();

    // AR and W on the same edge to the same word, then a fresh read.
    a = set_addr(1);
    aw_go(a, 4'd12, 8'd0, 3'd3);
    fork
      w_go(64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1'b1);
      ar_go(a, 4'd13, 8'd0, 3'd3);
    join
    drain();
    ar_go(a, 4'd14, 8'd0, 3'd3);
    drain();

    // Reset while the write response is pending; the data must still land.
    wr(set_addr(9), 4'd1, 8'd0, 3'd3, 64'h5555_6666_7777_8888, 8'hF0, 1'b1);
    pulse_reset();
    ar_go(set_addr(9), 4'd2, 8'd0, 3'd3);
    drain();

    // Reset in the read wait window: no response may appear.
    ar_go(set_addr(0), 4'd3, 8'd0, 3'd3);
    pulse_reset();
    repeat (6) @(posedge clock);
    #1;
    ar_go(set_addr(0), 4'd4, 8'd0, 3'd3);
    drain();

    bp = 35;
    fork
      repeat (60) wr(rnd_addr(), 4'($urandom),
                     ($urandom_range(7) == 0) ? 8'($urandom_range(255, 1)) : 8'd0,
                     ($urandom_range(7) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3)),
                     {$urandom, $urandom}, 8'($urandom), ($urandom_range(7) != 0));
      repeat (60) ar_go(rnd_addr(), 4'($urandom),
                        ($urandom_range(7) == 0) ? 8'($urandom_range(255, 1)) : 8'd0,
                        ($urandom_range(7) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3)));
    join
    drain();
    bp = 0;
    repeat (4) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
